// File: rtl/tqu_rrs_sched_pkg.sv
// tqu_pkg: shared types and constants for the TQU tag dequeue scheduler.
//   TQU_NUM_Q     - tag queues per scheduler instance (2 EPLs x 4 ports)
//   TQU_TAG_W     - tag width
//   TQU_CRED_W    - per-queue transmit credit counter width
//   TQU_CRED_INIT - credits loaded at reset and on IDLE->RUN
package tqu_pkg;

  localparam int TQU_NUM_Q     = 8;
  localparam int TQU_TAG_W     = 20;
  localparam int TQU_CRED_W    = 4;
  localparam int TQU_CRED_INIT = 8;
  localparam int TQU_QID_W     = $clog2(TQU_NUM_Q);

  typedef logic [TQU_QID_W-1:0]  tqu_qid_t;
  typedef logic [TQU_TAG_W-1:0]  tqu_tag_t;
  typedef logic [TQU_CRED_W-1:0] tqu_cred_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tqu_sched_state_e;

endpackage

// File: rtl/tqu_rrs_sched_rr_arb.sv
// tqu_rr_arb: combinational round-robin arbiter.
//   req     - per-queue request vector
//   ptr     - queue index where the search starts (highest priority)
//   upd_en  - allow the pointer to advance past this cycle's winner
//   gnt     - one-hot grant
//   gnt_idx - encoded grant index
//   gnt_vld - any request granted
//   ptr_nxt - next pointer value: winner+1 when granted and enabled, else ptr
// NUM_Q must be a power of two so index arithmetic wraps naturally.
module tqu_rr_arb #(
  parameter  int NUM_Q = 8,
  localparam int QW    = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [QW-1:0]    ptr,
  input  logic             upd_en,
  output logic [NUM_Q-1:0] gnt,
  output logic [QW-1:0]    gnt_idx,
  output logic             gnt_vld,
  output logic [QW-1:0]    ptr_nxt
);

  always_comb begin
    logic [QW-1:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      idx = ptr + QW'(i);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt     = gnt_vld ? (NUM_Q'(1) << gnt_idx) : '0;
  assign ptr_nxt = (upd_en && gnt_vld) ? gnt_idx + QW'(1) : ptr;

endmodule

// File: rtl/tqu_rrs_sched.sv
// tqu_rrs_sched: tag dequeue scheduler for one egress read interface.
// Picks at most one eligible tag queue per cycle by round robin, gated by
// per-queue transmit credits, and presents the popped tag through a single
// registered valid/ready output stage.
//   clk, rst          - clock, synchronous active-high reset
//   cfg_en            - scheduler enable
//   q_enable, q_valid - per-queue enable mask and non-empty flags
//   q_tag             - head tag per queue
//   q_pop             - one-hot pop, combinational from the grant
//   rd_valid/tag/qid  - output stage, rd_ready accepts
//   cred_ret_valid/qid- one credit returned by the TCU
//   sched_idle        - IDLE with empty output stage
//   err_cred_ovf      - sticky: credit returned to a saturated counter
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | disabled, no grants; credits reload on exit to RUN
// ST_RUN   | arbitrating and granting
// ST_DRAIN | disabled, waiting for the output stage to empty
module tqu_rrs_sched
  import tqu_pkg::*;
#(
  parameter  int NUM_Q     = TQU_NUM_Q,
  parameter  int TAG_W     = TQU_TAG_W,
  parameter  int CRED_W    = TQU_CRED_W,
  parameter  int CRED_INIT = TQU_CRED_INIT,
  localparam int QW        = $clog2(NUM_Q)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic [NUM_Q-1:0]            q_enable,
  input  logic [NUM_Q-1:0]            q_valid,
  input  logic [NUM_Q-1:0][TAG_W-1:0] q_tag,
  output logic [NUM_Q-1:0]            q_pop,
  output logic                        rd_valid,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [QW-1:0]               rd_qid,
  input  logic                        rd_ready,
  input  logic                        cred_ret_valid,
  input  logic [QW-1:0]               cred_ret_qid,
  output logic                        sched_idle,
  output logic                        err_cred_ovf
);

  localparam logic [CRED_W-1:0] CRED_MAX = '1;
  localparam logic [CRED_W-1:0] CRED_LD  = CRED_W'(CRED_INIT);

  tqu_sched_state_e              state;
  logic [NUM_Q-1:0][CRED_W-1:0]  cred, cred_nxt;
  logic [QW-1:0]                 rr_ptr, rr_ptr_nxt, gnt_idx;
  logic [NUM_Q-1:0]              elig, req, gnt;
  logic                          gnt_vld, gnt_en, reload, ovf_hit;

  // Grants only in RUN and only when the output stage can take a new tag;
  // rst gating keeps q_pop quiet while reset is being applied.
  assign gnt_en = !rst && (state == ST_RUN) && (!rd_valid || rd_ready);
  assign reload = (state == ST_IDLE) && cfg_en;

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = q_valid[i] && q_enable[i] && (cred[i] != '0);
    end
  end

  assign req = elig & {NUM_Q{gnt_en}};

  tqu_rr_arb #(.NUM_Q(NUM_Q)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .upd_en  (gnt_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .ptr_nxt (rr_ptr_nxt)
  );

  assign q_pop = gnt;

  // Reload applies first, then the cycle's return/grant on top of it.
  // A grant and a return on the same queue cancel; a lone return to a
  // saturated counter holds it and flags the overflow.
  always_comb begin
    logic [CRED_W-1:0] base;
    logic              inc, dec;
    base     = '0;
    inc      = 1'b0;
    dec      = 1'b0;
    cred_nxt = cred;
    ovf_hit  = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      base        = reload ? CRED_LD : cred[i];
      inc         = cred_ret_valid && (cred_ret_qid == QW'(i));
      dec         = gnt[i];
      cred_nxt[i] = base;
      if (inc && !dec) begin
        if (base == CRED_MAX) ovf_hit = 1'b1;
        else                  cred_nxt[i] = base + 1'b1;
      end else if (dec && !inc) begin
        cred_nxt[i] = base - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      cred         <= {NUM_Q{CRED_LD}};
      rd_valid     <= 1'b0;
      rd_tag       <= '0;
      rd_qid       <= '0;
      err_cred_ovf <= 1'b0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      cred   <= cred_nxt;
      if (ovf_hit) err_cred_ovf <= 1'b1;

      if (gnt_vld) begin
        rd_valid <= 1'b1;
        rd_tag   <= q_tag[gnt_idx];
        rd_qid   <= gnt_idx;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end

      case (state)
        ST_IDLE:  if (cfg_en) state <= ST_RUN;
        ST_RUN:   if (!cfg_en) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (cfg_en)         state <= ST_RUN;
          else if (!rd_valid) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign sched_idle = (state == ST_IDLE) && !rd_valid;

endmodule

// File: tb/tb_tqu_rrs_sched.sv
module tb_tqu_rrs_sched;

  localparam int NQ = 8;
  localparam int TW = 20;
  localparam int QW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_en;
  logic [NQ-1:0]         q_enable, q_valid, q_pop;
  logic [NQ-1:0][TW-1:0] q_tag;
  logic                  rd_valid, rd_ready;
  logic [TW-1:0]         rd_tag;
  logic [QW-1:0]         rd_qid;
  logic                  cred_ret_valid;
  logic [QW-1:0]         cred_ret_qid;
  logic                  sched_idle, err_cred_ovf;

  always #5 clk = ~clk;

  tqu_rrs_sched dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_en         (cfg_en),
    .q_enable       (q_enable),
    .q_valid        (q_valid),
    .q_tag          (q_tag),
    .q_pop          (q_pop),
    .rd_valid       (rd_valid),
    .rd_tag         (rd_tag),
    .rd_qid         (rd_qid),
    .rd_ready       (rd_ready),
    .cred_ret_valid (cred_ret_valid),
    .cred_ret_qid   (cred_ret_qid),
    .sched_idle     (sched_idle),
    .err_cred_ovf   (err_cred_ovf)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Upstream queue emulation: each queue's head tag is {qid, pop count}.
  int seq [NQ];

  task automatic set_tags();
    for (int i = 0; i < NQ; i++) q_tag[i] = TW'(i * 4096 + (seq[i] % 4096));
  endtask

  // Reference model
  typedef struct {
    logic [QW-1:0] qid;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  int   m_state;  // 0 idle, 1 run, 2 drain
  int   m_ptr;
  int   m_cred [NQ];
  logic m_rv;
  logic m_ovf;
  int   grants_seen = 0;

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    for (int i = 0; i < NQ; i++) m_cred[i] = 8;
    sb.delete();
  endtask

  // One clock: check at negedge against the model, advance the model
  // after the posedge. Caller drives inputs before calling.
  task automatic cycle();
    logic [NQ-1:0] ep, popped;
    logic          found;
    int            g, base, n_state, n_ptr;
    logic          n_rv, inc, dec;
    int            n_cred [NQ];
    @(negedge clk);
    ep    = '0;
    found = 1'b0;
    g     = 0;
    if (!rst && m_state == 1 && (!m_rv || rd_ready)) begin
      for (int k = 0; k < NQ; k++) begin
        int q;
        q = (m_ptr + k) % NQ;
        if (!found && q_valid[q] && q_enable[q] && m_cred[q] != 0) begin
          found = 1'b1;
          g     = q;
        end
      end
    end
    if (found) ep[g] = 1'b1;
    chk("q_pop", q_pop, ep);
    chk("rd_valid", rd_valid, m_rv);
    chk("sched_idle", sched_idle, (m_state == 0) && !m_rv);
    chk("err_cred_ovf", err_cred_ovf, m_ovf);
    if (m_rv) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow: rd_valid=1 with no expected tag");
      end else begin
        chk("rd_qid", rd_qid, sb[0].qid);
        chk("rd_tag", rd_tag, sb[0].tag);
      end
    end
    grants_seen += $countones(q_pop);
    popped = q_pop;

    n_state = m_state;
    n_ptr   = m_ptr;
    n_rv    = m_rv;
    for (int q = 0; q < NQ; q++) n_cred[q] = m_cred[q];
    if (!rst) begin
      if (m_rv && rd_ready && sb.size() > 0) void'(sb.pop_front());
      if (found) sb.push_back('{qid: QW'(g), tag: q_tag[g]});
      n_rv = found ? 1'b1 : (rd_ready ? 1'b0 : m_rv);
      for (int q = 0; q < NQ; q++) begin
        base = (m_state == 0 && cfg_en) ? 8 : m_cred[q];
        inc  = cred_ret_valid && (cred_ret_qid == QW'(q));
        dec  = found && (g == q);
        if (inc && !dec) begin
          if (base == 15) m_ovf = 1'b1;
          else            base = base + 1;
        end else if (dec && !inc) begin
          base = base - 1;
        end
        n_cred[q] = base;
      end
      if (found) n_ptr = (g + 1) % NQ;
      case (m_state)
        0: if (cfg_en) n_state = 1;
        1: if (!cfg_en) n_state = 2;
        default: if (cfg_en) n_state = 1; else if (!m_rv) n_state = 0;
      endcase
    end

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_state = n_state;
      m_ptr   = n_ptr;
      m_rv    = n_rv;
      for (int q = 0; q < NQ; q++) m_cred[q] = n_cred[q];
    end
    for (int i = 0; i < NQ; i++) if (popped[i]) seq[i]++;
    set_tags();
  endtask

  // Stimulus segments with hand-derived grant totals
  typedef struct {
    logic          cfg;
    logic [NQ-1:0] en;
    logic [NQ-1:0] vld;
    logic          rdy;
    logic          ret_v;
    logic [QW-1:0] ret_q;
    int            n;
    int            exp_gnt;
    logic          exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vt [NVEC];

  initial begin
    logic [TW-1:0] hold_tag;
    int            g0, wait_n;
    logic          seen;

    vt[0]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0,  3,  0, 1'b0}; // idle
    vt[1]  = '{1'b1, 8'hff, 8'hff, 1'b1, 1'b0, 3'd0, 70, 64, 1'b0}; // basic RR
    vt[2]  = '{1'b1, 8'hff, 8'hff, 1'b1, 1'b0, 3'd0, 10,  0, 1'b0}; // credits exhausted
    vt[3]  = '{1'b1, 8'hff, 8'h08, 1'b1, 1'b1, 3'd3,  1,  0, 1'b0}; // return to q3
    vt[4]  = '{1'b1, 8'hff, 8'h08, 1'b1, 1'b0, 3'd0,  4,  1, 1'b0}; // exactly one more
    vt[5]  = '{1'b1, 8'hff, 8'h00, 1'b1, 1'b1, 3'd5,  1,  0, 1'b0}; // credit q5
    vt[6]  = '{1'b1, 8'hff, 8'h20, 1'b1, 1'b1, 3'd5,  1,  1, 1'b0}; // grant+return q5
    vt[7]  = '{1'b1, 8'hff, 8'h20, 1'b1, 1'b0, 3'd0,  3,  1, 1'b0}; // cred5 was kept
    vt[8]  = '{1'b0, 8'hff, 8'h00, 1'b1, 1'b0, 3'd0,  3,  0, 1'b0}; // RUN->DRAIN->IDLE
    vt[9]  = '{1'b1, 8'hff, 8'h00, 1'b1, 1'b0, 3'd0,  1,  0, 1'b0}; // reload to 8
    vt[10] = '{1'b1, 8'hff, 8'h00, 1'b1, 1'b1, 3'd0,  7,  0, 1'b0}; // q0 -> 15
    vt[11] = '{1'b1, 8'hff, 8'h00, 1'b1, 1'b1, 3'd0,  1,  0, 1'b1}; // overflow
    vt[12] = '{1'b1, 8'hff, 8'h01, 1'b1, 1'b0, 3'd0, 20, 15, 1'b1}; // 15 credits on q0
    vt[13] = '{1'b1, 8'h00, 8'hff, 1'b1, 1'b0, 3'd0,  3,  0, 1'b1}; // all masked

    for (int i = 0; i < NQ; i++) seq[i] = 0;
    set_tags();
    rst = 1'b1; cfg_en = 1'b0; q_enable = '0; q_valid = '0; rd_ready = 1'b0;
    cred_ret_valid = 1'b0; cred_ret_qid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_tag", rd_tag, '0);
    chk("rst_rd_qid", rd_qid, '0);
    chk("rst_q_pop", q_pop, '0);
    chk("rst_sched_idle", sched_idle, 1'b1);
    chk("rst_err", err_cred_ovf, 1'b0);
    model_reset();
    rst = 1'b0;

    for (int s = 0; s < NVEC; s++) begin
      cfg_en = vt[s].cfg; q_enable = vt[s].en; q_valid = vt[s].vld;
      rd_ready = vt[s].rdy; cred_ret_valid = vt[s].ret_v; cred_ret_qid = vt[s].ret_q;
      g0 = grants_seen;
      for (int c = 0; c < vt[s].n; c++) cycle();
      chk($sformatf("seg%0d_grants", s), grants_seen - g0, vt[s].exp_gnt);
      chk($sformatf("seg%0d_err", s), err_cred_ovf, vt[s].exp_err);
    end
    cred_ret_valid = 1'b0;

    // Backpressure: one tag on q1 held for 5 cycles
    cfg_en = 1'b1; q_enable = 8'hff; q_valid = 8'h02; rd_ready = 1'b0;
    hold_tag = q_tag[1];
    cycle();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("bp_q_pop", q_pop, '0);
      chk("bp_rd_tag", rd_tag, hold_tag);
      chk("bp_rd_qid", rd_qid, 3'd1);
    end
    q_valid = 8'h00; rd_ready = 1'b1;
    cycle();
    chk("bp_rd_valid_after", rd_valid, 1'b0);
    chk("bp_sb_empty", sb.size(), 0);

    // Drain with a held tag
    q_valid = 8'h02; rd_ready = 1'b0;
    cycle();
    cfg_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("drain_q_pop", q_pop, '0);
      chk("drain_not_idle", sched_idle, 1'b0);
    end
    rd_ready = 1'b1;
    wait_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      cycle();
      wait_n++;
      if (sched_idle) seen = 1'b1;
    end
    chk("drain_idle_seen", seen, 1'b1);
    chk("drain_idle_cycles", wait_n, 2);

    // Reset mid-stream
    cfg_en = 1'b1; q_valid = 8'hff;
    repeat (4) cycle();
    chk("pre_rst_rd_valid", rd_valid, 1'b1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_err", err_cred_ovf, 1'b0);
    chk("mid_rst_idle", sched_idle, 1'b1);
    rst = 1'b0; cfg_en = 1'b0; q_valid = '0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
